ibex_bcp_pipe: RTL and testbench

IBEX_BCP_PIPE -- requirements
Module: ibex_bcp_pipe

---
 rtl/ibex_pkg.sv | 27 ++
 rtl/ibex_bcp_cmp.sv | 88 ++++++++
 rtl/ibex_bcp_pipe.sv | 171 +++++++++++++++++
 tb/tb_ibex_bcp_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the bounds-check pipeline: operation and cause encodings,
// plus the predicate that recognises a region tag.
package ibex_pkg;

  typedef enum logic [1:0] {
    BCP_ACCESS = 2'd0,
    BCP_ARITH  = 2'd1,
    BCP_SETAG  = 2'd2,
    BCP_RSVD   = 2'd3
  } bcp_op_e;

  // Lower value means higher priority when several causes apply at once.
  typedef enum logic [2:0] {
    CAUSE_NONE         = 3'd0,
    CAUSE_TAG_INVALID  = 3'd1,
    CAUSE_REGION_BAD   = 3'd2,
    CAUSE_TAG_MISMATCH = 3'd3,
    CAUSE_UNDERFLOW    = 3'd4,
    CAUSE_OVERFLOW     = 3'd5
  } bcp_cause_e;

  // A tag names a table region when its two most significant bits are set.
  function automatic logic is_region_tag(input logic [1:0] tag_msbs);
    return tag_msbs == 2'b11;
  endfunction

endpackage

// File: rtl/ibex_bcp_cmp.sv
// Combinational cause evaluation for one request held in stage 1:
// tag validity, region sanity, tag agreement, then the bounds compare.
module ibex_bcp_cmp
  import ibex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TagWidth = 8
) (
  input  bcp_op_e               i_op,
  input  logic [1:0]            i_size,
  input  logic [TagWidth-1:0]   i_src_tag,
  input  logic [XLEN-1:0]       i_res,
  input  logic [TagWidth-1:0]   i_newtag,
  input  logic [XLEN-1:0]       i_src_start,
  input  logic [XLEN-1:0]       i_src_end,
  input  logic [XLEN-1:0]       i_new_start,
  input  logic [XLEN-1:0]       i_new_end,
  output bcp_cause_e            o_cause
);

  localparam int ALEN = XLEN - TagWidth;

  function automatic logic tag_invalid(input logic [TagWidth-1:0] tag);
    return (tag == '0) || (tag == '1);
  endfunction

  // A region is unusable if its bounds are inverted or its two entries disagree on the tag.
  function automatic logic region_bad(input logic [XLEN-1:0] s, input logic [XLEN-1:0] e);
    return (s[ALEN-1:0] > e[ALEN-1:0]) || (s[XLEN-1:ALEN] != e[XLEN-1:ALEN]);
  endfunction

  logic            w_src_region;
  logic            w_new_region;
  logic            w_src_bad;
  logic            w_new_bad;
  logic            w_mismatch;
  logic            w_check_bounds;
  logic [ALEN-1:0] w_mask;
  logic [ALEN-1:0] w_lo;
  logic [ALEN-1:0] w_hi;

  assign w_src_region = is_region_tag(i_src_tag[TagWidth-1 -: 2]);
  assign w_new_region = is_region_tag(i_newtag[TagWidth-1 -: 2]);
  assign w_src_bad    = region_bad(i_src_start, i_src_end);
  assign w_new_bad    = region_bad(i_new_start, i_new_end);

  // SETAG checks the new tag itself; the other ops check that the tag survived the arithmetic.
  assign w_mismatch = (i_op == BCP_SETAG)
                    ? (tag_invalid(i_newtag) || (w_new_region && w_new_bad))
                    : (i_src_tag != i_res[XLEN-1:ALEN]);

  // Bounds only make sense against a source region, and for SETAG only when the new tag is a region too.
  assign w_check_bounds = w_src_region && ((i_op != BCP_SETAG) || w_new_region);

  // Build the [lo, hi] span that must fit inside the source region.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave it undriven and infer a latch.
    w_mask = '0;
    w_lo   = i_res[ALEN-1:0];
    w_hi   = i_res[ALEN-1:0];
    case (i_size)
      2'd0:    w_mask = '0;
      2'd1:    w_mask = ALEN'(1);
      default: w_mask = ALEN'(3);
    endcase
    case (i_op)
      BCP_ACCESS: w_hi = i_res[ALEN-1:0] | w_mask;
      BCP_SETAG: begin
        w_lo = i_new_start[ALEN-1:0];
        w_hi = i_new_end[ALEN-1:0];
      end
      default: ;
    endcase
  end

  // Priority-encode the causes, lowest number first.
  always_comb begin
    o_cause = CAUSE_NONE;
    if (i_op != BCP_RSVD) begin
      if (tag_invalid(i_src_tag))                      o_cause = CAUSE_TAG_INVALID;
      else if (w_src_region && w_src_bad)              o_cause = CAUSE_REGION_BAD;
      else if (w_mismatch)                             o_cause = CAUSE_TAG_MISMATCH;
      else if (w_check_bounds && (w_lo < i_src_start[ALEN-1:0])) o_cause = CAUSE_UNDERFLOW;
      else if (w_check_bounds && (w_hi > i_src_end[ALEN-1:0]))   o_cause = CAUSE_OVERFLOW;
    end
  end

endmodule

// File: rtl/ibex_bcp_pipe.sv
// Two-stage bounds-check pipeline: stage 1 holds the request and its looked-up
// region entries, stage 2 holds the resulting cause. A sticky fault record keeps
// the first failing response until software clears it.
module ibex_bcp_pipe
  import ibex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int TagWidth   = 8,
  parameter int NumRegions = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_we_i,
  input  logic [$clog2(NumRegions)-1:0] cfg_idx_i,
  input  logic [XLEN-1:0]               cfg_wdata_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [1:0]                    req_op_i,
  input  logic [1:0]                    req_size_i,
  input  logic [XLEN-1:0]               req_ptr_i,
  input  logic [XLEN-1:0]               req_res_i,
  input  logic [TagWidth-1:0]           req_newtag_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic                          rsp_err_o,
  output logic [2:0]                    rsp_cause_o,
  output logic                          fault_valid_o,
  output logic [XLEN-1:0]               fault_addr_o,
  output logic [2:0]                    fault_cause_o,
  input  logic                          fault_clr_i
);

  localparam int ALEN = XLEN - TagWidth;
  localparam int IdxW = $clog2(NumRegions);
  localparam int KW   = IdxW - 1;

  if (((NumRegions % 2) != 0) || (NumRegions < 4)) begin : g_bad_num_regions
    $error("ibex_bcp_pipe: NumRegions must be even and at least 4");
  end

  typedef struct packed {
    bcp_op_e             op;
    logic [1:0]          size;
    logic [XLEN-1:0]     ptr;
    logic [XLEN-1:0]     res;
    logic [TagWidth-1:0] newtag;
    logic [XLEN-1:0]     src_start;
    logic [XLEN-1:0]     src_end;
    logic [XLEN-1:0]     new_start;
    logic [XLEN-1:0]     new_end;
  } s1_t;

  logic [XLEN-1:0] r_table [2**IdxW];
  logic            r_s1_valid;
  s1_t             r_s1;
  logic            r_s2_valid;
  bcp_cause_e      r_s2_cause;
  logic [XLEN-1:0] r_s2_faddr;
  logic            r_fault_valid;
  logic [XLEN-1:0] r_fault_addr;
  bcp_cause_e      r_fault_cause;

  logic            w_stall;
  logic            w_accept;
  logic [KW-1:0]   w_src_k;
  logic [KW-1:0]   w_new_k;
  s1_t             w_s1_next;
  bcp_cause_e      w_cause;
  logic            w_rsp_fire;
  logic            w_fault_evt;

  assign w_stall     = r_s2_valid & ~rsp_ready_i;
  assign req_ready_o = ~r_s1_valid | ~w_stall;
  assign w_accept    = req_valid_i & req_ready_o;

  // Region index comes from the tag bits just above the start/end select bit.
  assign w_src_k = req_ptr_i[ALEN+IdxW-1:ALEN+1];
  assign w_new_k = req_newtag_i[IdxW-1:1];

  assign w_s1_next.op        = bcp_op_e'(req_op_i);
  assign w_s1_next.size      = req_size_i;
  assign w_s1_next.ptr       = req_ptr_i;
  assign w_s1_next.res       = req_res_i;
  assign w_s1_next.newtag    = req_newtag_i;
  assign w_s1_next.src_start = r_table[{w_src_k, 1'b0}];
  assign w_s1_next.src_end   = r_table[{w_src_k, 1'b1}];
  assign w_s1_next.new_start = r_table[{w_new_k, 1'b0}];
  assign w_s1_next.new_end   = r_table[{w_new_k, 1'b1}];

  ibex_bcp_cmp #(
    .XLEN     (XLEN),
    .TagWidth (TagWidth)
  ) u_cmp (
    .i_op        (r_s1.op),
    .i_size      (r_s1.size),
    .i_src_tag   (r_s1.ptr[XLEN-1:ALEN]),
    .i_res       (r_s1.res),
    .i_newtag    (r_s1.newtag),
    .i_src_start (r_s1.src_start),
    .i_src_end   (r_s1.src_end),
    .i_new_start (r_s1.new_start),
    .i_new_end   (r_s1.new_end),
    .o_cause     (w_cause)
  );

  // Region table: a write lands at the clock edge, so a lookup in the same cycle still reads the old entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the table is built from flops rather than a RAM macro, so clearing every entry on reset is legal here.
      for (int i = 0; i < 2**IdxW; i++) r_table[i] <= '0;
    end else if (cfg_we_i && (int'(cfg_idx_i) < NumRegions)) begin
      r_table[cfg_idx_i] <= cfg_wdata_i;
    end
  end

  // Stage 1: take a new request whenever there is room, otherwise hold or drain.
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1       <= w_s1_next;
    end else if (!w_stall) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: capture the compare result; frozen while the consumer back-pressures.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s2_valid <= 1'b0;
      r_s2_cause <= CAUSE_NONE;
      r_s2_faddr <= '0;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      r_s2_cause <= r_s1_valid ? w_cause : CAUSE_NONE;
      r_s2_faddr <= (r_s1.op == BCP_SETAG) ? r_s1.ptr : r_s1.res;
    end
  end

  assign rsp_valid_o = r_s2_valid;
  assign rsp_cause_o = r_s2_cause;
  assign rsp_err_o   = (r_s2_cause != CAUSE_NONE);

  assign w_rsp_fire  = r_s2_valid & rsp_ready_i;
  assign w_fault_evt = w_rsp_fire & rsp_err_o;

  // Sticky fault record: first error wins, a clear in the same cycle lets a new error through.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fault_valid <= 1'b0;
      r_fault_addr  <= '0;
      r_fault_cause <= CAUSE_NONE;
    end else if (w_fault_evt && (!r_fault_valid || fault_clr_i)) begin
      r_fault_valid <= 1'b1;
      r_fault_addr  <= r_s2_faddr;
      r_fault_cause <= r_s2_cause;
    end else if (fault_clr_i) begin
      r_fault_valid <= 1'b0;
      r_fault_addr  <= '0;
      r_fault_cause <= CAUSE_NONE;
    end
  end

  assign fault_valid_o = r_fault_valid;
  assign fault_addr_o  = r_fault_addr;
  assign fault_cause_o = r_fault_cause;

endmodule

// File: tb/tb_ibex_bcp_pipe.sv
// Directed bench for ibex_bcp_pipe: a reference model computes each expected
// cause when a request is accepted, a scoreboard queue pairs it with the response.
module tb_ibex_bcp_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_we_i = 1'b0;
  logic [2:0]  cfg_idx_i = '0;
  logic [31:0] cfg_wdata_i = '0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = '0;
  logic [1:0]  req_size_i = '0;
  logic [31:0] req_ptr_i = '0;
  logic [31:0] req_res_i = '0;
  logic [7:0]  req_newtag_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic        rsp_err_o;
  logic [2:0]  rsp_cause_o;
  logic        fault_valid_o;
  logic [31:0] fault_addr_o;
  logic [2:0]  fault_cause_o;
  logic        fault_clr_i = 1'b0;

  ibex_bcp_pipe dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cfg_we_i      (cfg_we_i),
    .cfg_idx_i     (cfg_idx_i),
    .cfg_wdata_i   (cfg_wdata_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_size_i    (req_size_i),
    .req_ptr_i     (req_ptr_i),
    .req_res_i     (req_res_i),
    .req_newtag_i  (req_newtag_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_err_o     (rsp_err_o),
    .rsp_cause_o   (rsp_cause_o),
    .fault_valid_o (fault_valid_o),
    .fault_addr_o  (fault_addr_o),
    .fault_cause_o (fault_cause_o),
    .fault_clr_i   (fault_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [2:0]  cause;
    logic [31:0] faddr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_table [8];
  logic        m_fv = 1'b0;
  logic [31:0] m_faddr = '0;
  logic [2:0]  m_fcause = '0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_rsp = 0;
  logic        last_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic region_bad(input logic [31:0] s, input logic [31:0] e);
    return (s[23:0] > e[23:0]) || (s[31:24] != e[31:24]);
  endfunction

  // Reference model of the cause for one request against the model table.
  function automatic logic [2:0] model(input logic [1:0] op, input logic [1:0] size,
                                       input logic [31:0] ptr, input logic [31:0] res,
                                       input logic [7:0] nt);
    logic [7:0]  st;
    logic [31:0] s, e, ns, ne;
    logic [23:0] lo, hi;
    logic        src_reg, new_reg, nt_bad;
    st      = ptr[31:24];
    src_reg = (st[7:6] == 2'b11);
    new_reg = (nt[7:6] == 2'b11);
    s  = m_table[{st[2:1], 1'b0}];
    e  = m_table[{st[2:1], 1'b1}];
    ns = m_table[{nt[2:1], 1'b0}];
    ne = m_table[{nt[2:1], 1'b1}];
    nt_bad = (nt == 8'h00) || (nt == 8'hFF) || (new_reg && region_bad(ns, ne));
    lo = res[23:0];
    hi = res[23:0];
    if (op == 2'd0) hi = res[23:0] | ((size == 2'd0) ? 24'd0 : (size == 2'd1) ? 24'd1 : 24'd3);
    if (op == 2'd2) begin lo = ns[23:0]; hi = ne[23:0]; end
    if (op == 2'd3) return 3'd0;
    if (st == 8'h00 || st == 8'hFF) return 3'd1;
    if (src_reg && region_bad(s, e)) return 3'd2;
    if ((op == 2'd2) ? nt_bad : (st != res[31:24])) return 3'd3;
    if (src_reg && (op != 2'd2 || new_reg)) begin
      if (lo < s[23:0]) return 3'd4;
      if (hi > e[23:0]) return 3'd5;
    end
    return 3'd0;
  endfunction

  // One clock: sample at the falling edge, let the DUT update, then mirror state into the model.
  task automatic tick();
    logic        rst_s, clr, do_we, err_hs;
    logic [2:0]  we_idx;
    logic [31:0] we_data;
    exp_t        e;
    @(negedge clk_i);
    rst_s   = rst_i;
    clr     = fault_clr_i;
    do_we   = cfg_we_i;
    we_idx  = cfg_idx_i;
    we_data = cfg_wdata_i;
    err_hs  = 1'b0;
    last_acc = req_valid_i && req_ready_o && !rst_i;
    if (last_acc) begin
      e.cause = model(req_op_i, req_size_i, req_ptr_i, req_res_i, req_newtag_i);
      e.faddr = (req_op_i == 2'd2) ? req_ptr_i : req_res_i;
      sb.push_back(e);
    end
    if (rsp_valid_o && rsp_ready_i && !rst_i) begin
      n_rsp++;
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid_o), 64'(0));
      end else begin
        e = sb.pop_front();
        check("rsp_cause", 64'(rsp_cause_o), 64'(e.cause));
        check("rsp_err", 64'(rsp_err_o), 64'(e.cause != 3'd0));
        err_hs = (e.cause != 3'd0);
      end
    end
    if (!rst_s) begin
      if (err_hs && (!m_fv || clr)) begin
        m_fv = 1'b1; m_faddr = e.faddr; m_fcause = e.cause;
      end else if (clr) begin
        m_fv = 1'b0; m_faddr = '0; m_fcause = '0;
      end
    end
    @(posedge clk_i);
    #1;
    if (rst_s) begin
      sb.delete();
      for (int i = 0; i < 8; i++) m_table[i] = '0;
      m_fv = 1'b0; m_faddr = '0; m_fcause = '0;
    end else if (do_we) begin
      m_table[we_idx] = we_data;
    end
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [31:0] data);
    cfg_we_i = 1'b1; cfg_idx_i = idx; cfg_wdata_i = data;
    tick();
    cfg_we_i = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] size, input logic [31:0] ptr,
                      input logic [31:0] res, input logic [7:0] nt);
    req_valid_i = 1'b1; req_op_i = op; req_size_i = size;
    req_ptr_i = ptr; req_res_i = res; req_newtag_i = nt;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) check("accept_timeout", 64'(last_acc), 64'(1));
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic check_fault(input string t);
    check({t, "_fvalid"}, 64'(fault_valid_o), 64'(m_fv));
    check({t, "_faddr"},  64'(fault_addr_o),  64'(m_faddr));
    check({t, "_fcause"}, 64'(fault_cause_o), 64'(m_fcause));
  endtask

  initial begin
    int rsp_before;
    for (int i = 0; i < 8; i++) m_table[i] = '0;

    // Reset state
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_req_ready", 64'(req_ready_o), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check("rst_rsp_err",   64'(rsp_err_o),   64'(0));
    check("rst_rsp_cause", 64'(rsp_cause_o), 64'(0));
    check_fault("rst");
    check("rst_fault_cause_zero", 64'(fault_cause_o), 64'(0));

    // Region 0 and region 1 share the same bounds; region 2 is inverted (malformed).
    cfg_write(3'd0, 32'hC100_1000);
    cfg_write(3'd1, 32'hC100_10FF);
    cfg_write(3'd2, 32'hC100_1000);
    cfg_write(3'd3, 32'hC100_10FF);
    cfg_write(3'd4, 32'hC100_2000);
    cfg_write(3'd5, 32'hC100_1000);

    // In-bounds word access and two-cycle latency
    send(2'd0, 2'd2, 32'hC300_1000, 32'hC300_10FC, 8'h00);
    check("lat_cycle1", 64'(rsp_valid_o), 64'(0));
    tick();
    check("lat_cycle2", 64'(rsp_valid_o), 64'(1));
    drain();

    // Bounds cases: word rounded up exactly to the end, overflow, underflow, malformed region
    send(2'd0, 2'd2, 32'hC300_1000, 32'hC300_10FE, 8'h00);
    send(2'd0, 2'd2, 32'hC300_1000, 32'hC300_1100, 8'h00);
    send(2'd0, 2'd0, 32'hC300_1000, 32'hC300_0FFF, 8'h00);
    send(2'd0, 2'd1, 32'hC300_1000, 32'hC300_10FE, 8'h00);
    send(2'd1, 2'd0, 32'hC500_1000, 32'hC500_1000, 8'h00);
    send(2'd1, 2'd0, 32'hC300_1000, 32'hC300_1100, 8'h00);
    drain();
    check_fault("overflow");

    // SETAG into a malformed and into a good region; non-region tags; reserved op
    send(2'd2, 2'd0, 32'hC300_1000, 32'h0000_0000, 8'hC5);
    send(2'd2, 2'd0, 32'hC300_1050, 32'h0000_0000, 8'hC1);
    send(2'd1, 2'd0, 32'h1200_0000, 32'h12FF_FFFF, 8'h00);
    send(2'd1, 2'd0, 32'h1200_0000, 32'h1300_0000, 8'h00);
    send(2'd3, 2'd0, 32'h0000_0000, 32'hFFFF_FFFF, 8'h00);
    drain();
    check_fault("sticky_first");

    // Sticky record: clear, capture cause 1, ignore a second fault, then clear with a concurrent cause 3
    fault_clr_i = 1'b1;
    tick();
    fault_clr_i = 1'b0;
    check_fault("cleared");
    send(2'd1, 2'd0, 32'h0000_1234, 32'h0000_1238, 8'h00);
    drain();
    check_fault("cause1");
    send(2'd1, 2'd0, 32'hC500_1000, 32'hC500_1000, 8'h00);
    drain();
    check_fault("held");
    send(2'd0, 2'd2, 32'h1200_0010, 32'h1300_0010, 8'h00);
    tick();
    check("clr_race_rsp_valid", 64'(rsp_valid_o), 64'(1));
    fault_clr_i = 1'b1;
    tick();
    fault_clr_i = 1'b0;
    check_fault("clr_race");
    check("clr_race_cause3", 64'(fault_cause_o), 64'(3));
    fault_clr_i = 1'b1;
    tick();
    fault_clr_i = 1'b0;
    check_fault("clr_only");

    // Back-pressure: three requests, consumer stalled for five cycles
    rsp_before = n_rsp;
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_op_i = 2'd0; req_size_i = 2'd2;
    req_ptr_i = 32'hC300_1000; req_res_i = 32'hC300_10FC; req_newtag_i = 8'h00;
    tick();
    check("stall_acc_a", 64'(last_acc), 64'(1));
    req_op_i = 2'd1; req_ptr_i = 32'hFF00_0000; req_res_i = 32'hFF00_0000;
    tick();
    check("stall_acc_b", 64'(last_acc), 64'(1));
    req_op_i = 2'd0; req_ptr_i = 32'h1200_0010; req_res_i = 32'h1300_0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_not_acc_c", 64'(last_acc), 64'(0));
    end
    check("stall_req_ready", 64'(req_ready_o), 64'(0));
    check("stall_rsp_held", 64'(rsp_valid_o), 64'(1));
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_acc) break;
    end
    check("stall_acc_c", 64'(last_acc), 64'(1));
    req_valid_i = 1'b0;
    drain();
    check("stall_rsp_count", 64'(n_rsp - rsp_before), 64'(3));
    check_fault("stall");

    // Table write and lookup in the same cycle: first request sees the old end, the next the new one
    cfg_we_i = 1'b1; cfg_idx_i = 3'd3; cfg_wdata_i = 32'hC100_1FFF;
    send(2'd0, 2'd2, 32'hC300_1000, 32'hC300_1100, 8'h00);
    cfg_we_i = 1'b0;
    send(2'd0, 2'd2, 32'hC300_1000, 32'hC300_1100, 8'h00);
    drain();

    // Reset with both stages occupied: nothing may come out afterwards
    rsp_ready_i = 1'b0;
    send(2'd0, 2'd2, 32'hC300_1000, 32'hC300_1010, 8'h00);
    send(2'd0, 2'd2, 32'hC300_1000, 32'hC300_1020, 8'h00);
    check("full_rsp_valid", 64'(rsp_valid_o), 64'(1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check("midrst_req_ready", 64'(req_ready_o), 64'(1));
    check_fault("midrst");
    rsp_ready_i = 1'b1;
    rsp_before = n_rsp;
    for (int i = 0; i < 6; i++) tick();
    check("no_late_rsp", 64'(n_rsp - rsp_before), 64'(0));

    // Table was cleared by reset: region 1 is now [0,0], so this access overflows
    send(2'd0, 2'd2, 32'hC300_1000, 32'hC300_1000, 8'h00);
    drain();
    check_fault("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
